// File: rtl/mem_access_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_pkg
//  Description : Shared types and constants for the data-memory access
//                controller: op codes, FSM state encoding, exception codes.
//  Revision    : 1.0  initial release
// ============================================================================
package mem_access_pkg;

    typedef enum logic [2:0] {
        OP_LW  = 3'd0,
        OP_LH  = 3'd1,
        OP_LHU = 3'd2,
        OP_LB  = 3'd3,
        OP_LBU = 3'd4,
        OP_SW  = 3'd5,
        OP_SB  = 3'd6,
        OP_SH  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    localparam logic [1:0] EXC_NONE  = 2'd0;
    localparam logic [1:0] EXC_ALIGN = 2'd1;
    localparam logic [1:0] EXC_RANGE = 2'd2;

    // Any op that ends in a memory write.
    function automatic logic is_store(input op_e op);
        return (op == OP_SW) || (op == OP_SB) || (op == OP_SH);
    endfunction

    // Word ops need both low bits clear, half-word ops need bit 0 clear.
    function automatic logic is_misaligned(input op_e op, input logic [1:0] lo);
        case (op)
            OP_LW, OP_SW:         return lo != 2'b00;
            OP_LH, OP_LHU, OP_SH: return lo[0];
            default:              return 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_ctrl_if
//  Description : Request/response bundle from the MEM stage plus the word
//                memory bus. The controller uses the slave view; the
//                pipeline/memory side uses the master view.
//  Revision    : 1.0  initial release
// ============================================================================
interface mem_access_ctrl_if;
    import mem_access_pkg::*;

    logic        req_valid;
    logic        req_ready;
    op_e         req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] req_pc;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_exc;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_pc;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, req_pc, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_exc,
               mem_addr, mem_wdata, mem_we, mem_pc
    );

    modport master (
        output req_valid, req_op, req_addr, req_wdata, req_pc, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_exc,
               mem_addr, mem_wdata, mem_we, mem_pc
    );

endinterface
`default_nettype wire

// File: rtl/mem_lane_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mem_lane_unit
//  Description : Combinational byte-lane logic: extracts and extends load
//                data, and merges sub-word store data into the read word.
//                Lanes are little-endian (byte k at bits [8k+7:8k]).
//  Revision    : 1.0  initial release
// ============================================================================
module mem_lane_unit
    import mem_access_pkg::*;
(
    input  op_e         op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rdata,
    input  logic [15:0] wdata_lo,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Select the addressed byte / half-word, then extend or merge by op.
    always_comb begin
        byte_sel   = rdata[7:0];
        half_sel   = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        load_data  = 32'd0;
        merge_data = rdata;

        case (addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase

        case (op)
            OP_LW:  load_data = rdata;
            OP_LH:  load_data = {{16{half_sel[15]}}, half_sel};
            OP_LHU: load_data = {16'd0, half_sel};
            OP_LB:  load_data = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU: load_data = {24'd0, byte_sel};
            OP_SB: begin
                case (addr_lo)
                    2'd0:    merge_data = {rdata[31:8], wdata_lo[7:0]};
                    2'd1:    merge_data = {rdata[31:16], wdata_lo[7:0], rdata[7:0]};
                    2'd2:    merge_data = {rdata[31:24], wdata_lo[7:0], rdata[15:0]};
                    default: merge_data = {wdata_lo[7:0], rdata[23:0]};
                endcase
            end
            OP_SH: begin
                merge_data = addr_lo[1] ? {wdata_lo, rdata[15:0]}
                                        : {rdata[31:16], wdata_lo};
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_ctrl
//  Description : MEM-stage initiator for a word-only data memory. Loads are
//                one read, SW is one write, SB/SH are read-modify-write.
//                Misaligned and out-of-range requests complete without any
//                memory access.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_access_ctrl
    import mem_access_pkg::*;
#(
    parameter int ADDR_WIDTH = 12
) (
    input  logic               clk,
    input  logic               reset,
    mem_access_ctrl_if.slave   bus
);

    state_e      state_q,  state_d;
    op_e         op_q,     op_d;
    logic [31:0] addr_q,   addr_d;
    logic [31:0] wdata_q,  wdata_d;
    logic [31:0] pc_q,     pc_d;
    logic [1:0]  exc_q,    exc_d;
    logic [31:0] rdata_q,  rdata_d;
    logic [31:0] merge_q,  merge_d;

    logic        accept;
    logic [1:0]  req_exc;
    logic [31:0] lane_load;
    logic [31:0] lane_merge;

    assign accept = bus.req_valid && (state_q == ST_IDLE);

    // Classify the incoming request; alignment outranks range.
    always_comb begin
        req_exc = EXC_NONE;
        if (is_misaligned(bus.req_op, bus.req_addr[1:0])) begin
            req_exc = EXC_ALIGN;
        end else if ((bus.req_addr >> (ADDR_WIDTH + 2)) != 32'd0) begin
            req_exc = EXC_RANGE;
        end
    end

    mem_lane_unit u_lane (
        .op         (op_q),
        .addr_lo    (addr_q[1:0]),
        .rdata      (bus.mem_rdata),
        .wdata_lo   (wdata_q[15:0]),
        .load_data  (lane_load),
        .merge_data (lane_merge)
    );

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            op_q    <= OP_LW;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            pc_q    <= 32'd0;
            exc_q   <= EXC_NONE;
            rdata_q <= 32'd0;
            merge_q <= 32'd0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            pc_q    <= pc_d;
            exc_q   <= exc_d;
            rdata_q <= rdata_d;
            merge_q <= merge_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (req_exc != EXC_NONE) begin
                        state_d = ST_RESP;
                    end else if (bus.req_op == OP_SW) begin
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_READ;
                    end
                end
            end
            ST_READ:  state_d = is_store(op_q) ? ST_WRITE : ST_RESP;
            ST_WRITE: state_d = ST_RESP;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Datapath latches: capture on accept, load result or RMW word in READ.
    always_comb begin
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        pc_d    = pc_q;
        exc_d   = exc_q;
        rdata_d = rdata_q;
        merge_d = merge_q;
        if (accept) begin
            op_d    = bus.req_op;
            addr_d  = bus.req_addr;
            wdata_d = bus.req_wdata;
            pc_d    = bus.req_pc;
            exc_d   = req_exc;
            rdata_d = 32'd0;
        end else if (state_q == ST_READ) begin
            if (is_store(op_q)) begin
                merge_d = lane_merge;
            end else begin
                rdata_d = lane_load;
            end
        end
    end

    // FSM-decoded outputs; reset gates the write strobe immediately.
    always_comb begin
        bus.req_ready  = (state_q == ST_IDLE);
        bus.resp_valid = (state_q == ST_RESP);
        bus.mem_we     = (state_q == ST_WRITE) && !reset;
    end

    assign bus.mem_addr   = {addr_q[31:2], 2'b00};
    assign bus.mem_wdata  = (op_q == OP_SW) ? wdata_q : merge_q;
    assign bus.mem_pc     = pc_q;
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_exc   = exc_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_access_ctrl
//  Description : Directed self-checking bench for mem_access_ctrl with a
//                small word-memory model behind the memory bus.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_access_ctrl;
    import mem_access_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;

    mem_access_ctrl_if bus ();

    mem_access_ctrl #(.ADDR_WIDTH(12)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Word memory model: 16 words, combinational read, preloaded in reset.
    logic [31:0] mem_arr [16];
    int          we_count = 0;
    logic [31:0] last_we_addr  = 32'd0;
    logic [31:0] last_we_data  = 32'd0;
    logic [31:0] last_we_pc    = 32'd0;

    assign bus.mem_rdata = mem_arr[bus.mem_addr[5:2]];

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) mem_arr[i] <= 32'd0;
            mem_arr[0]  <= 32'h8899AABB;
            mem_arr[2]  <= 32'hCAFEF00D;
            mem_arr[4]  <= 32'h11223344;
            mem_arr[15] <= 32'h12345678;
        end else if (bus.mem_we) begin
            mem_arr[bus.mem_addr[5:2]] <= bus.mem_wdata;
        end
        if (bus.mem_we) begin
            we_count     <= we_count + 1;
            last_we_addr <= bus.mem_addr;
            last_we_data <= bus.mem_wdata;
            last_we_pc   <= bus.mem_pc;
        end
    end

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request, wait (bounded) for the response and check it.
    task automatic do_req(input string tag, input op_e op, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] pc,
                          input int exp_lat, input logic [31:0] exp_rdata,
                          input logic [1:0] exp_exc, input int exp_writes);
        int lat;
        int we_before;
        we_before     = we_count;
        check({tag, "_ready"}, {31'd0, bus.req_ready}, 32'd1);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_pc    = pc;
        tick();
        bus.req_valid = 1'b0;
        bus.req_addr  = 32'hDEAD_BEEF;
        lat = 1;
        while (!bus.resp_valid && lat < 8) begin
            tick();
            lat++;
        end
        check({tag, "_lat"},   lat, exp_lat);
        check({tag, "_rdata"}, bus.resp_rdata, exp_rdata);
        check({tag, "_exc"},   {30'd0, bus.resp_exc}, {30'd0, exp_exc});
        tick();
        check({tag, "_pulse"}, {31'd0, bus.resp_valid}, 32'd0);
        check({tag, "_writes"}, we_count - we_before, exp_writes);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.req_valid = 1'b0;
        bus.req_op    = OP_LW;
        bus.req_addr  = 32'd0;
        bus.req_wdata = 32'd0;
        bus.req_pc    = 32'd0;
        tick();
        tick();
        check("rst_ready",  {31'd0, bus.req_ready}, 32'd1);
        check("rst_valid",  {31'd0, bus.resp_valid}, 32'd0);
        check("rst_we",     {31'd0, bus.mem_we}, 32'd0);
        check("rst_maddr",  bus.mem_addr, 32'd0);
        check("rst_mwdata", bus.mem_wdata, 32'd0);
        check("rst_mpc",    bus.mem_pc, 32'd0);
        check("rst_rdata",  bus.resp_rdata, 32'd0);
        reset = 1'b0;
        tick();
        check("idle_valid", {31'd0, bus.resp_valid}, 32'd0);

        // Loads from 0x8899AABB.
        do_req("lb3",  OP_LB,  32'h3, 32'h0, 32'h100, 2, 32'hFFFFFF88, EXC_NONE, 0);
        do_req("lhu2", OP_LHU, 32'h2, 32'h0, 32'h104, 2, 32'h00008899, EXC_NONE, 0);
        do_req("lh0",  OP_LH,  32'h0, 32'h0, 32'h108, 2, 32'hFFFFAABB, EXC_NONE, 0);
        do_req("lbu1", OP_LBU, 32'h1, 32'h0, 32'h10C, 2, 32'h000000AA, EXC_NONE, 0);
        do_req("lw0",  OP_LW,  32'h0, 32'h0, 32'h110, 2, 32'h8899AABB, EXC_NONE, 0);
        do_req("lwtop", OP_LW, 32'h3FFC, 32'h0, 32'h114, 2, 32'h12345678, EXC_NONE, 0);

        // Sub-word RMW stores on 0x11223344 at 0x10.
        do_req("sb11", OP_SB, 32'h11, 32'h0000_00EE, 32'h400, 3, 32'h0, EXC_NONE, 1);
        check("sb11_addr", last_we_addr, 32'h10);
        check("sb11_data", last_we_data, 32'h1122EE44);
        check("sb11_pc",   last_we_pc,   32'h400);
        do_req("sh12", OP_SH, 32'h12, 32'hFFFF_BEEF, 32'h404, 3, 32'h0, EXC_NONE, 1);
        check("sh12_data", last_we_data, 32'hBEEFEE44);
        do_req("lw10", OP_LW, 32'h10, 32'h0, 32'h408, 2, 32'hBEEFEE44, EXC_NONE, 0);

        // Faults: no memory access, one-cycle latency.
        do_req("sw2",    OP_SW, 32'h2,    32'h1234, 32'h500, 1, 32'h0, EXC_ALIGN, 0);
        do_req("lw4000", OP_LW, 32'h4000, 32'h0,    32'h504, 1, 32'h0, EXC_RANGE, 0);
        do_req("sh4001", OP_SH, 32'h4001, 32'h0,    32'h508, 1, 32'h0, EXC_ALIGN, 0);
        do_req("lh1",    OP_LH, 32'h1,    32'h0,    32'h50C, 1, 32'h0, EXC_ALIGN, 0);

        // Reset while the write strobe is up.
        begin
            int we_before;
            we_before     = we_count;
            bus.req_valid = 1'b1;
            bus.req_op    = OP_SB;
            bus.req_addr  = 32'h20;
            bus.req_wdata = 32'h55;
            tick();
            bus.req_valid = 1'b0;
            tick();
            check("mid_we_pre", {31'd0, bus.mem_we}, 32'd1);
            reset = 1'b1;
            #1;
            check("mid_we_rst", {31'd0, bus.mem_we}, 32'd0);
            tick();
            reset = 1'b0;
            check("mid_ready",  {31'd0, bus.req_ready}, 32'd1);
            check("mid_valid",  {31'd0, bus.resp_valid}, 32'd0);
            check("mid_writes", we_count - we_before, 32'd0);
            tick();
        end

        // Back-to-back LW then SW with req_valid held high.
        begin
            int we_before;
            int resps;
            we_before     = we_count;
            resps         = 0;
            bus.req_valid = 1'b1;
            bus.req_op    = OP_LW;
            bus.req_addr  = 32'h8;
            tick();
            bus.req_op    = OP_SW;
            bus.req_addr  = 32'hC;
            bus.req_wdata = 32'hA5A5_5A5A;
            bus.req_pc    = 32'h600;
            check("b2b_rdy1", {31'd0, bus.req_ready}, 32'd0);
            tick();
            check("b2b_rdy2", {31'd0, bus.req_ready}, 32'd0);
            if (bus.resp_valid) resps++;
            check("b2b_lw",   bus.resp_rdata, 32'hCAFEF00D);
            tick();
            check("b2b_rdy3", {31'd0, bus.req_ready}, 32'd1);
            tick();
            bus.req_valid = 1'b0;
            check("b2b_we",   {31'd0, bus.mem_we}, 32'd1);
            for (int i = 0; i < 4; i++) begin
                if (bus.resp_valid) resps++;
                tick();
            end
            check("b2b_resps",  resps, 32'd2);
            check("b2b_writes", we_count - we_before, 32'd1);
            check("b2b_mem",    mem_arr[3], 32'hA5A55A5A);
            check("b2b_wpc",    last_we_pc, 32'h600);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
